// File: rtl/adc_pack_pkg.sv
// Shared defaults for the ADC sample packer and its continuity checker.
package adc_pack_pkg;

  localparam int SAMPLE_W_DEF    = 16;   // bits per ADC sample
  localparam int LANES_DEF       = 4;    // samples per packed output word
  localparam int FRAME_WORDS_DEF = 256;  // output words per frame
  localparam int FRAME_CNT_W     = 16;   // width of the completed-frame counter

endpackage : adc_pack_pkg

// File: rtl/adc_step_checker.sv
// Sample continuity checker: flags (sticky) any accepted sample that is not
// exactly one step (+1 or -1, modulo 2^SAMPLE_W) away from the previous one.
// The first sample after reset or err_clr only seeds the reference.
module adc_step_checker
  import adc_pack_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                accept,
  input  logic                err_clr,
  output logic                step_err
);

  logic [SAMPLE_W-1:0] r_prev;
  logic                r_prev_vld;
  logic                r_err;
  logic [SAMPLE_W-1:0] w_delta;
  logic                w_step_bad;

  // Modular difference: +1 and -1 (all ones) are the only legal steps.
  assign w_delta    = sample - r_prev;
  assign w_step_bad = accept && r_prev_vld &&
                      (w_delta != SAMPLE_W'(1)) && (w_delta != '1);

  // Reference-valid flag and sticky error; err_clr wins over a same-cycle error.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
    end else if (err_clr) begin
      r_prev_vld <= 1'b0;
      r_err      <= 1'b0;
    end else if (accept) begin
      r_prev_vld <= 1'b1;
      if (w_step_bad) r_err <= 1'b1;
    end
  end

  // Previous-sample register; only meaningful while r_prev_vld is set.
  // NOTE: data-only register left without reset; its validity flag is reset instead.
  always_ff @(posedge clk) begin
    if (accept) r_prev <= sample;
  end

  assign step_err = r_err;

endmodule : adc_step_checker

// File: rtl/adc_sample_packer.sv
// ADC sample packer: collects LANES samples (first sample at the LSBs) into
// one output word, presents it on a valid/ready output with a one-entry
// output register, marks the last word of each frame and counts frames.
// LANES must be at least 2.
module adc_sample_packer
  import adc_pack_pkg::*;
#(
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int LANES       = LANES_DEF,
  parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [SAMPLE_W-1:0]       s_data,
  input  logic                      s_valid,
  output logic                      s_ready,
  output logic [SAMPLE_W*LANES-1:0] m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic [FRAME_CNT_W-1:0]    frame_cnt,
  input  logic                      err_clr,
  output logic                      step_err
);

  localparam int LANE_W = (LANES > 1)       ? $clog2(LANES)       : 1;
  localparam int WORD_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam int ACC_W  = (LANES - 1) * SAMPLE_W;

  logic [LANE_W-1:0]         r_lane;
  logic [WORD_W-1:0]         r_word;
  logic [ACC_W-1:0]          r_acc;
  logic [SAMPLE_W*LANES-1:0] r_m_data;
  logic                      r_m_valid;
  logic [FRAME_CNT_W-1:0]    r_frame_cnt;

  logic              w_last_lane;
  logic              w_word_last;
  logic              w_accept;
  logic              w_complete;
  logic              w_xfer;
  logic [LANE_W-1:0] w_lane_nxt;
  logic [WORD_W-1:0] w_word_nxt;

  // Handshake decode. The last lane may only be taken when the output
  // register is empty or draining this cycle, so no word is ever lost.
  assign w_last_lane = (r_lane == LANE_W'(LANES - 1));
  assign w_word_last = (r_word == WORD_W'(FRAME_WORDS - 1));
  assign s_ready     = !w_last_lane || !r_m_valid || m_ready;
  assign w_accept    = s_valid && s_ready;
  assign w_complete  = w_accept && w_last_lane;
  assign w_xfer      = r_m_valid && m_ready;

  // Wrapping successors of the lane and word counters.
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    w_lane_nxt = r_lane + 1'b1;
    w_word_nxt = r_word + 1'b1;
    if (w_last_lane) w_lane_nxt = '0;
    if (w_word_last) w_word_nxt = '0;
  end

  // Partial-word accumulator for lanes 0..LANES-2; the last lane bypasses it.
  always_ff @(posedge clk) begin
    if (w_accept && !w_last_lane) begin
      for (int k = 0; k < LANES - 1; k++) begin
        if (r_lane == LANE_W'(k)) r_acc[k*SAMPLE_W +: SAMPLE_W] <= s_data;
      end
    end
  end

  // Lane/word counters, output register and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lane      <= '0;
      r_word      <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) r_lane <= w_lane_nxt;

      // A completing word reloads the register even while the old one
      // drains, keeping m_valid high with no bubble.
      if (w_complete) begin
        r_m_data  <= {s_data, r_acc};
        r_m_valid <= 1'b1;
      end else if (w_xfer) begin
        r_m_valid <= 1'b0;
      end

      if (w_xfer) begin
        r_word <= w_word_nxt;
        if (w_word_last) r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // r_word only moves on a transfer, so m_last is stable while stalled.
  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_valid && w_word_last;
  assign frame_cnt = r_frame_cnt;

  adc_step_checker #(
    .SAMPLE_W (SAMPLE_W)
  ) u_step_checker (
    .clk      (clk),
    .reset    (reset),
    .sample   (s_data),
    .accept   (w_accept),
    .err_clr  (err_clr),
    .step_err (step_err)
  );

endmodule : adc_sample_packer

// File: tb/tb_adc_sample_packer.sv
// Testbench for adc_sample_packer (FRAME_WORDS=4 so frame boundaries are
// reached quickly). Accepted samples go into a FIFO model; every output
// transfer must carry the next LANES samples in order.
module tb_adc_sample_packer;

  localparam int SW = 16;
  localparam int LN = 4;
  localparam int FW = 4;

  localparam logic [63:0] W1 = 64'h0004_0003_0002_0001;
  localparam logic [63:0] W2 = 64'h0008_0007_0006_0005;
  localparam logic [63:0] W3 = 64'h000C_000B_000A_0009;

  logic             clk;
  logic             reset;
  logic [SW-1:0]    s_data;
  logic             s_valid;
  logic             s_ready;
  logic [SW*LN-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [15:0]      frame_cnt;
  logic             err_clr;
  logic             step_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [SW-1:0] q[$];
  int            words_xfered = 0;
  int            acc_count    = 0;
  int            last_seen    = 0;
  bit            last_acc     = 1'b0;

  typedef struct {
    logic          sv;
    logic [SW-1:0] sd;
    logic          mr;
    logic          exp_sr;
    logic          exp_mv;
    logic [63:0]   exp_md;
    logic          exp_ml;
  } vec_t;

  vec_t tbl[19];

  adc_sample_packer #(
    .SAMPLE_W    (SW),
    .LANES       (LN),
    .FRAME_WORDS (FW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .frame_cnt (frame_cnt),
    .err_clr   (err_clr),
    .step_err  (step_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs shortly after a rising edge and let them settle.
  task automatic drive(input logic sv, input logic [SW-1:0] sd, input logic mr, input logic clr);
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    err_clr = clr;
    #2;
  endtask

  // Record the handshakes that the coming edge will perform, score any
  // output transfer against the FIFO model, then cross the edge.
  task automatic advance();
    logic [63:0] w;
    last_acc = s_valid && s_ready;
    if (last_acc) begin
      q.push_back(s_data);
      acc_count++;
    end
    if (m_valid && m_ready) begin
      if (q.size() < LN) begin
        check("sb_underflow", 64'(q.size()), 64'(LN));
      end else begin
        w = '0;
        for (int k = 0; k < LN; k++) w[k*SW +: SW] = q.pop_front();
        check("word_data", m_data, w);
        check("word_last", 64'(m_last), 64'((words_xfered % FW) == FW - 1));
      end
      if (m_last) last_seen++;
      words_xfered++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic sv, input logic [SW-1:0] sd, input logic mr, input logic clr);
    drive(sv, sd, mr, clr);
    advance();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    check("rst_s_ready_during", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_s_ready_after", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", m_data, 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("rst_step_err", 64'(step_err), 64'd0);
    q.delete();
    words_xfered = 0;
    acc_count    = 0;
    last_seen    = 0;
  endtask

  initial begin
    logic [SW-1:0] nxt;
    int            cycles;

    // Cycle-by-cycle vectors: packing of 1..4, then a stall with a full
    // output register and a second word completing behind it.
    //            sv    sd       mr    sr    mv    md  ml
    tbl[0]  = '{1'b1, 16'd1,  1'b1, 1'b1, 1'b0, 64'd0, 1'b0};
    tbl[1]  = '{1'b1, 16'd2,  1'b1, 1'b1, 1'b0, 64'd0, 1'b0};
    tbl[2]  = '{1'b1, 16'd3,  1'b1, 1'b1, 1'b0, 64'd0, 1'b0};
    tbl[3]  = '{1'b1, 16'd4,  1'b1, 1'b1, 1'b0, 64'd0, 1'b0};
    tbl[4]  = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b1, W1,    1'b0};
    tbl[5]  = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, W1,    1'b0};
    tbl[6]  = '{1'b1, 16'd5,  1'b0, 1'b1, 1'b0, W1,    1'b0};
    tbl[7]  = '{1'b1, 16'd6,  1'b0, 1'b1, 1'b0, W1,    1'b0};
    tbl[8]  = '{1'b1, 16'd7,  1'b0, 1'b1, 1'b0, W1,    1'b0};
    tbl[9]  = '{1'b1, 16'd8,  1'b0, 1'b1, 1'b0, W1,    1'b0};
    tbl[10] = '{1'b1, 16'd9,  1'b0, 1'b1, 1'b1, W2,    1'b0};
    tbl[11] = '{1'b1, 16'd10, 1'b0, 1'b1, 1'b1, W2,    1'b0};
    tbl[12] = '{1'b1, 16'd11, 1'b0, 1'b1, 1'b1, W2,    1'b0};
    tbl[13] = '{1'b1, 16'd12, 1'b0, 1'b0, 1'b1, W2,    1'b0};
    tbl[14] = '{1'b1, 16'd12, 1'b0, 1'b0, 1'b1, W2,    1'b0};
    tbl[15] = '{1'b1, 16'd12, 1'b1, 1'b1, 1'b1, W2,    1'b0};
    tbl[16] = '{1'b0, 16'd0,  1'b0, 1'b1, 1'b1, W3,    1'b0};
    tbl[17] = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b1, W3,    1'b0};
    tbl[18] = '{1'b0, 16'd0,  1'b1, 1'b1, 1'b0, W3,    1'b0};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].sv, tbl[i].sd, tbl[i].mr, 1'b0);
      check($sformatf("vec%0d_s_ready", i), 64'(s_ready), 64'(tbl[i].exp_sr));
      check($sformatf("vec%0d_m_valid", i), 64'(m_valid), 64'(tbl[i].exp_mv));
      check($sformatf("vec%0d_m_data", i), m_data, tbl[i].exp_md);
      check($sformatf("vec%0d_m_last", i), 64'(m_last), 64'(tbl[i].exp_ml));
      advance();
    end
    check("vec_step_err", 64'(step_err), 64'd0);

    // Frame boundary: 16 ramp samples -> m_last on the 4th word only.
    do_reset();
    for (int i = 1; i <= 16; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    check("frame_last_shown", 64'(m_last), 64'd1);
    check("frame_valid_shown", 64'(m_valid), 64'd1);
    check("frame_cnt_before", 64'(frame_cnt), 64'd0);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    check("frame_cnt_after", 64'(frame_cnt), 64'd1);
    check("frame_valid_after", 64'(m_valid), 64'd0);
    check("frame_last_count", 64'(last_seen), 64'd1);
    check("frame_step_err", 64'(step_err), 64'd0);

    // Continuity checker.
    do_reset();
    cyc(1'b1, 16'd5, 1'b1, 1'b0);
    cyc(1'b1, 16'd6, 1'b1, 1'b0);
    cyc(1'b1, 16'd7, 1'b1, 1'b0);
    check("step_ok_ramp", 64'(step_err), 64'd0);
    cyc(1'b1, 16'd9, 1'b1, 1'b0);
    check("step_jump_sets", 64'(step_err), 64'd1);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    check("step_sticky", 64'(step_err), 64'd1);
    cyc(1'b0, 16'd0, 1'b1, 1'b1);
    check("step_clr", 64'(step_err), 64'd0);
    cyc(1'b1, 16'h7FFE, 1'b1, 1'b0);
    cyc(1'b1, 16'h7FFD, 1'b1, 1'b0);
    check("step_exempt_down", 64'(step_err), 64'd0);
    cyc(1'b0, 16'd0, 1'b1, 1'b1);
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    cyc(1'b1, 16'h0000, 1'b1, 1'b0);
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("step_wrap_ok", 64'(step_err), 64'd0);
    cyc(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("step_equal_sets", 64'(step_err), 64'd1);
    cyc(1'b0, 16'd0, 1'b1, 1'b1);
    cyc(1'b1, 16'd100, 1'b1, 1'b0);
    cyc(1'b1, 16'd300, 1'b1, 1'b1);
    check("step_clr_beats_err", 64'(step_err), 64'd0);
    cyc(1'b1, 16'd500, 1'b1, 1'b0);
    check("step_exempt_after_clr", 64'(step_err), 64'd0);

    // Reset with a pending word and a partial word in flight.
    do_reset();
    for (int i = 20; i < 26; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    check("midword_pending", 64'(m_valid), 64'd1);
    do_reset();
    for (int i = 10; i < 14; i++) cyc(1'b1, 16'(i), 1'b1, 1'b0);
    check("midword_valid", 64'(m_valid), 64'd1);
    check("midword_data", m_data, 64'h000D_000C_000B_000A);
    check("midword_frame_cnt", 64'(frame_cnt), 64'd0);
    cyc(1'b0, 16'd0, 1'b1, 1'b0);
    check("midword_drained", 64'(m_valid), 64'd0);

    // Random backpressure with a random-walk (+/-1) stream.
    do_reset();
    nxt    = 16'($urandom);
    cycles = 0;
    while (acc_count < 10000 && cycles < 60000) begin
      cyc(1'($urandom_range(0, 3) != 0), nxt, 1'($urandom_range(0, 2) != 0), 1'b0);
      if (last_acc) nxt = ($urandom_range(0, 1) != 0) ? 16'(nxt + 16'd1) : 16'(nxt - 16'd1);
      cycles++;
    end
    check("rand_accept_count", 64'(acc_count), 64'd10000);
    for (int i = 0; i < 20 && (q.size() > 0 || m_valid); i++) cyc(1'b0, nxt, 1'b1, 1'b0);
    check("rand_queue_left", 64'(q.size()), 64'd0);
    check("rand_words", 64'(words_xfered), 64'd2500);
    check("rand_frame_cnt", 64'(frame_cnt), 64'((words_xfered / FW) % 65536));
    check("rand_step_err", 64'(step_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_adc_sample_packer
